bus_ctrl: RTL and testbench

Pin-side bus controller sitting between the CPU core and the chip-level shared bus pins (12-bit address, 4-bit data, read/write direction). Accepts one CPU request at a time, latches it, sequences a setup/access/done transfer with configurable wait states, captures read data and returns a one-cycle acknowledge. The `bus_rw` output directly drives the output-enable of the four bidirectional data pins.

---
 rtl/bus_ctrl.sv | 129 ++++++++++++
 tb/tb_bus_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl.sv
// Pin-side bus controller: latches one CPU request, runs SETUP/ACCESS/DONE with wait states.
// Optional macro BUS_EXT_READY_EN: ACCESS also waits on bus_rdy, with a TIMEOUT error exit.
module bus_ctrl #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              busy,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_out,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic              bus_rw,
    input  logic              bus_rdy
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    localparam logic [7:0] WaitCyc = 8'(WAIT_CYC);

    state_e            state_q, state_d;
    logic              we_q;
    logic              rw_q;
    logic              err_q;
    logic [7:0]        wait_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              access_done;
    logic              access_err;

`ifdef BUS_EXT_READY_EN
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    // Ready wins over timeout when both land on the same cycle.
    always_comb begin
        access_done = 1'b0;
        access_err  = 1'b0;
        if (state_q == StAccess) begin
            if ((wait_cnt_q >= WaitCyc) && bus_rdy) begin
                access_done = 1'b1;
            end else if (wait_cnt_q == TimeoutCnt) begin
                access_done = 1'b1;
                access_err  = 1'b1;
            end
        end
    end
`else
    logic       unused_rdy;
    logic [7:0] unused_timeout;
    assign unused_rdy     = bus_rdy;
    assign unused_timeout = 8'(TIMEOUT);

    always_comb begin
        access_done = (state_q == StAccess) && (wait_cnt_q == WaitCyc);
        access_err  = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cpu_req) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (access_done) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            rw_q       <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if ((state_q == StIdle) && cpu_req) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_we ? cpu_wdata : '0;
            end
            if (state_q == StSetup) begin
                wait_cnt_q <= 8'd0;
            end else if (state_q == StAccess) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if (access_done) begin
                err_q <= access_err;
                if (!we_q) begin
                    rdata_q <= access_err ? '0 : bus_data_in;
                end
            end
            // Registered so the pin output-enable never glitches on state decode.
            rw_q <= (state_d == StAccess) && we_q;
        end
    end

    always_comb begin
        cpu_ack      = (state_q == StDone);
        cpu_err      = (state_q == StDone) && err_q;
        busy         = (state_q != StIdle);
        cpu_rdata    = rdata_q;
        bus_addr     = addr_q;
        bus_data_out = wdata_q;
        bus_rw       = rw_q;
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: directed cases plus random transactions against a
// transaction-level latency/data model.
module tb_bus_ctrl;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 4;
    localparam int WAIT_CYC = 1;
    localparam int TIMEOUT  = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;
    logic              busy;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data_out;
    logic [DATA_W-1:0] bus_data_in;
    logic              bus_rw;
    logic              bus_rdy;

    bus_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .WAIT_CYC(WAIT_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_err     (cpu_err),
        .busy        (busy),
        .bus_addr    (bus_addr),
        .bus_data_out(bus_data_out),
        .bus_data_in (bus_data_in),
        .bus_rw      (bus_rw),
        .bus_rdy     (bus_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the architecturally visible registers.
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_dout;
    logic [DATA_W-1:0] exp_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ack, input logic rw,
                             input logic bsy, input logic err);
        chk({tag, ".ack"}, 32'(cpu_ack), 32'(ack));
        chk({tag, ".rw"}, 32'(bus_rw), 32'(rw));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".err"}, 32'(cpu_err), 32'(err));
        chk({tag, ".addr"}, 32'(bus_addr), 32'(exp_addr));
        chk({tag, ".dout"}, 32'(bus_data_out), 32'(exp_dout));
        chk({tag, ".rdata"}, 32'(cpu_rdata), 32'(exp_rdata));
    endtask

    // One isolated transaction starting in an IDLE cycle; ends in the following IDLE cycle.
    task automatic txn(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] din,
                       input bit force_timeout);
        bit rdy_q[$];
        bit r;
        int len;
        bit err;
        len = WAIT_CYC + 1;
        err = 1'b0;
`ifdef BUS_EXT_READY_EN
        len = 0;
        for (int k = 0; k <= TIMEOUT; k++) begin
            r = force_timeout ? 1'b0 : ($urandom_range(3) == 0);
            rdy_q.push_back(r);
            if (len == 0 && r && k >= WAIT_CYC) len = k + 1;
        end
        if (len == 0) begin
            len = TIMEOUT + 1;
            err = 1'b1;
        end
`else
        for (int k = 0; k <= TIMEOUT; k++) begin
            r = force_timeout ? 1'b0 : 1'($urandom_range(1));
            rdy_q.push_back(r);
        end
`endif
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        tick();
        exp_addr = addr;
        exp_dout = we ? wdata : '0;
        check_all({tag, ".setup"}, 1'b0, 1'b0, 1'b1, 1'b0);
        // Mid-transfer CPU inputs must be ignored.
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom_range(1));
        cpu_addr  = ADDR_W'($urandom);
        cpu_wdata = DATA_W'($urandom);
        for (int k = 0; k < len; k++) begin
            tick();
            bus_rdy     = rdy_q[k];
            bus_data_in = (k == len - 1) ? din : DATA_W'($urandom);
            check_all({tag, ".access"}, 1'b0, we, 1'b1, 1'b0);
        end
        tick();
        if (!we) exp_rdata = err ? '0 : din;
        check_all({tag, ".done"}, 1'b1, 1'b0, 1'b1, err);
        bus_rdy = 1'b0;
        tick();
        check_all({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [ADDR_W-1:0] a_first;
        logic [ADDR_W-1:0] a_second;
        logic [DATA_W-1:0] d_first;
        logic [DATA_W-1:0] d_second;
        int c_ack1;
        int c_idle1;
        int c_ack2;
        int c_end;

        rst         = 1'b1;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        bus_data_in = '0;
        bus_rdy     = 1'b0;
        exp_addr    = '0;
        exp_dout    = '0;
        exp_rdata   = '0;
        tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        txn("read_abc", 1'b0, 12'hABC, 4'h0, 4'h5, 1'b0);
        txn("write_123", 1'b1, 12'h123, 4'h9, 4'h3, 1'b0);

        // Back-to-back reads with cpu_req held high.
        a_first  = 12'h456;
        a_second = 12'h789;
        d_first  = 4'hA;
        d_second = 4'h6;
        c_ack1   = 3 + WAIT_CYC;
        c_idle1  = 4 + WAIT_CYC;
        c_ack2   = 7 + 2 * WAIT_CYC;
        c_end    = 8 + 2 * WAIT_CYC;
        bus_rdy  = 1'b1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a_first;
        for (int c = 1; c <= c_end; c++) begin
            tick();
            if (c == 1) cpu_addr = a_second;
            if (c == c_idle1 + 1) cpu_req = 1'b0;
            if (c == c_ack1 - 1) bus_data_in = d_first;
            else if (c == c_ack2 - 1) bus_data_in = d_second;
            else bus_data_in = DATA_W'($urandom);
            chk("b2b.ack", 32'(cpu_ack), 32'(c == c_ack1 || c == c_ack2));
            chk("b2b.busy", 32'(busy), 32'(!(c == c_idle1 || c == c_end)));
            chk("b2b.rw", 32'(bus_rw), 32'(0));
            chk("b2b.addr", 32'(bus_addr), 32'((c <= c_idle1) ? a_first : a_second));
            if (c == c_ack1) chk("b2b.rdata1", 32'(cpu_rdata), 32'(d_first));
            if (c == c_ack2) chk("b2b.rdata2", 32'(cpu_rdata), 32'(d_second));
        end
        bus_rdy   = 1'b0;
        exp_addr  = a_second;
        exp_dout  = '0;
        exp_rdata = d_second;
        check_all("b2b.end", 1'b0, 1'b0, 1'b0, 1'b0);

        txn("no_rdy", 1'b0, 12'h0F0, 4'h0, 4'hC, 1'b1);

        for (int i = 0; i < 24; i++) begin
            txn("rand", 1'($urandom_range(1)), ADDR_W'($urandom), DATA_W'($urandom),
                DATA_W'($urandom), 1'b0);
        end

        // Reset in the middle of a write ACCESS.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 12'hFED;
        cpu_wdata = 4'h7;
        tick();
        cpu_req  = 1'b0;
        exp_addr = 12'hFED;
        exp_dout = 4'h7;
        tick();
        check_all("rst_mid.access", 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        exp_addr  = '0;
        exp_dout  = '0;
        exp_rdata = '0;
        check_all("rst_mid.edge1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("rst_mid.edge2", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_all("rst_mid.after", 1'b0, 1'b0, 1'b0, 1'b0);

        txn("after_rst", 1'b0, 12'h321, 4'h0, 4'hE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
